// File: rtl/ddr3_bclk_training_ctrl.sv
// ddr3_bclk_training_ctrl: sweeps the BCLK training IOD RX delay line from tap 0,
// finds the widest clean EARLY/LATE window and steps back to its centre.
// Optional macro BCLK_TRAIN_WINDOW_OUT_EN adds WIN_START/WIN_END outputs.
module ddr3_bclk_training_ctrl #(
  parameter int unsigned TAP_MAX       = 127,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_WINDOW    = 4
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [7:0] TAP_CENTER
`ifdef BCLK_TRAIN_WINDOW_OUT_EN
  ,
  output logic [7:0] WIN_START,
  output logic [7:0] WIN_END
`endif
);

  localparam int unsigned TAP_W   = 8;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
    S_EVAL, S_STEP, S_CENTER, S_FINISH, S_FAILED
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               edge_seen_q, edge_seen_d;
  logic               start_found_q, start_found_d;
  logic [TAP_W-1:0]   win_start_q, win_start_d;
  logic [TAP_W-1:0]   win_end_q, win_end_d;
  logic [TAP_W-1:0]   center_q, center_d;
  logic               phase_q, phase_d;

  logic               load_q, load_d;
  logic               move_q, move_d;
  logic               dir_q, dir_d;
  logic               clear_q, clear_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [TAP_W-1:0]   tap_center_q, tap_center_d;

  logic               sweep_end;
  logic               sf_n;
  logic [TAP_W-1:0]   ws_n, we_n, center_n;
  logic [TAP_W:0]     win_sum, win_width;
  logic               win_pass;

  // Window decision made during EVAL, in the priority order of the sweep rules
  always_comb begin
    sweep_end = 1'b0;
    sf_n      = start_found_q;
    ws_n      = win_start_q;
    we_n      = win_end_q;
    if (DELAY_LINE_OUT_OF_RANGE) begin
      sweep_end = 1'b1;
      we_n      = tap_q - TAP_W'(1);
    end else if (edge_seen_q && start_found_q) begin
      sweep_end = 1'b1;
      we_n      = tap_q - TAP_W'(1);
    end else begin
      if (!edge_seen_q && !start_found_q) begin
        ws_n = tap_q;
        sf_n = 1'b1;
      end
      if (tap_q == TAP_W'(TAP_MAX)) begin
        sweep_end = 1'b1;
        if (!edge_seen_q) we_n = tap_q;
      end
    end
    win_sum   = {1'b0, ws_n} + {1'b0, we_n};
    win_width = {1'b0, we_n} - {1'b0, ws_n} + (TAP_W+1)'(1);
    center_n  = win_sum[TAP_W:1];
    win_pass  = sf_n && (win_width >= (TAP_W+1)'(MIN_WINDOW));
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    cnt_d         = cnt_q;
    edge_seen_d   = edge_seen_q;
    start_found_d = start_found_q;
    win_start_d   = win_start_q;
    win_end_d     = win_end_q;
    center_d      = center_q;
    phase_d       = phase_q;
    case (state_q)
      S_IDLE, S_FINISH, S_FAILED: begin
        if (START) begin
          state_d       = S_LOAD;
          tap_d         = '0;
          start_found_d = 1'b0;
          win_start_d   = '0;
          win_end_d     = '0;
          center_d      = '0;
          phase_d       = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_CLEAR;
      S_CLEAR: begin
        edge_seen_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        edge_seen_d = edge_seen_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EVAL: begin
        start_found_d = sf_n;
        win_start_d   = ws_n;
        win_end_d     = we_n;
        if (!sweep_end) begin
          state_d = S_STEP;
        end else if (win_pass) begin
          center_d = center_n;
          phase_d  = (tap_q > center_n);
          state_d  = S_CENTER;
        end else begin
          state_d = S_FAILED;
        end
      end
      S_STEP: begin
        tap_d   = tap_q + TAP_W'(1);
        state_d = S_CLEAR;
      end
      S_CENTER: begin
        // phase 1 is a MOVE-high cycle, phase 0 the following low cycle
        if (phase_q) begin
          tap_d   = tap_q - TAP_W'(1);
          phase_d = 1'b0;
        end else if (tap_q > center_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = S_FINISH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    load_d       = (state_d == S_LOAD);
    clear_d      = (state_d == S_CLEAR);
    move_d       = (state_d == S_STEP) || ((state_d == S_CENTER) && phase_d);
    dir_d        = (state_d == S_STEP);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_FINISH) || (state_d == S_FAILED));
    done_d       = done_q;
    fail_d       = fail_q;
    tap_center_d = tap_center_q;
    if (state_d == S_LOAD) begin
      done_d       = 1'b0;
      fail_d       = 1'b0;
      tap_center_d = '0;
    end else if (state_d == S_FINISH) begin
      done_d       = 1'b1;
      tap_center_d = tap_d;
    end else if (state_d == S_FAILED) begin
      fail_d       = 1'b1;
      tap_center_d = '0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      tap_q         <= '0;
      cnt_q         <= '0;
      edge_seen_q   <= 1'b0;
      start_found_q <= 1'b0;
      win_start_q   <= '0;
      win_end_q     <= '0;
      center_q      <= '0;
      phase_q       <= 1'b0;
      load_q        <= 1'b0;
      move_q        <= 1'b0;
      dir_q         <= 1'b0;
      clear_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      tap_center_q  <= '0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      cnt_q         <= cnt_d;
      edge_seen_q   <= edge_seen_d;
      start_found_q <= start_found_d;
      win_start_q   <= win_start_d;
      win_end_q     <= win_end_d;
      center_q      <= center_d;
      phase_q       <= phase_d;
      load_q        <= load_d;
      move_q        <= move_d;
      dir_q         <= dir_d;
      clear_q       <= clear_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      tap_center_q  <= tap_center_d;
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign FAIL                    = fail_q;
  assign TAP_CENTER              = tap_center_q;

`ifdef BCLK_TRAIN_WINDOW_OUT_EN
  logic [TAP_W-1:0] win_start_out_q, win_end_out_q;

  // Window bounds captured once at sweep end and held with DONE/FAIL
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      win_start_out_q <= '0;
      win_end_out_q   <= '0;
    end else if ((state_q == S_EVAL) && sweep_end) begin
      win_start_out_q <= ws_n;
      win_end_out_q   <= we_n;
    end
  end

  assign WIN_START = win_start_out_q;
  assign WIN_END   = win_end_out_q;
`endif

endmodule

// File: tb/tb_ddr3_bclk_training_ctrl.sv
// Directed bench for ddr3_bclk_training_ctrl with a behavioural IOD lane model.
module tb_ddr3_bclk_training_ctrl;

  logic       FAB_CLK;
  logic       RESET_N;
  logic       START;
  logic       eye_early, eye_late, oor;
  logic       dl_load, dl_move, dl_dir, clr_flags;
  logic       busy, done, fail;
  logic [7:0] tap_center;
`ifdef BCLK_TRAIN_WINDOW_OUT_EN
  logic [7:0] win_start, win_end;
`endif

  ddr3_bclk_training_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .RESET_N                 (RESET_N),
    .START                   (START),
    .EYE_MONITOR_EARLY       (eye_early),
    .EYE_MONITOR_LATE        (eye_late),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS (clr_flags),
    .BUSY                    (busy),
    .DONE                    (done),
    .FAIL                    (fail),
    .TAP_CENTER              (tap_center)
`ifdef BCLK_TRAIN_WINDOW_OUT_EN
    ,
    .WIN_START               (win_start),
    .WIN_END                 (win_end)
`endif
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  int vectors = 0;
  int miscompares = 0;

  // IOD lane model: delay tap, dirty taps, out-of-range threshold
  logic [127:0] dirty_mask;
  int           oor_tap;
  int           mon_tap;
  int           load_cnt, inc_cnt, dec_cnt, overlap_cnt;

  assign eye_early = dirty_mask[7'(mon_tap)] && (mon_tap < 64);
  assign eye_late  = dirty_mask[7'(mon_tap)] && (mon_tap >= 64);
  assign oor       = (mon_tap >= oor_tap);

  always @(negedge FAB_CLK) begin
    if (dl_load) begin
      load_cnt++;
      mon_tap = 0;
    end
    if (dl_move) begin
      if (dl_dir) begin
        inc_cnt++;
        mon_tap++;
      end else begin
        dec_cnt++;
        mon_tap--;
      end
    end
    if (int'(dl_load) + int'(dl_move) + int'(clr_flags) > 1) overlap_cnt++;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge FAB_CLK);
    #1;
  endtask

  function automatic logic [127:0] mask_outside(input int lo, input int hi);
    logic [127:0] m;
    for (int i = 0; i < 128; i++) m[i] = (i < lo) || (i > hi);
    return m;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_load"},  int'(dl_load), 0);
    check_eq({tag, "_move"},  int'(dl_move), 0);
    check_eq({tag, "_dir"},   int'(dl_dir), 0);
    check_eq({tag, "_clear"}, int'(clr_flags), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
    check_eq({tag, "_done"},  int'(done), 0);
    check_eq({tag, "_fail"},  int'(fail), 0);
    check_eq({tag, "_tc"},    int'(tap_center), 0);
  endtask

  // Start a run, optionally re-pulse START while busy, and wait for DONE/FAIL
  task automatic run_training(input string tag, input int pulse_at, output int cycles);
    load_cnt = 0; inc_cnt = 0; dec_cnt = 0; overlap_cnt = 0;
    cycles = 0;
    START = 1'b1;
    do begin
      tick();
      cycles++;
      if (cycles == 1) begin
        check_eq({tag, "_load_latency"}, int'(dl_load), 1);
        check_eq({tag, "_busy_with_load"}, int'(busy), 1);
      end
      START = (cycles == pulse_at);
    end while (!(done || fail) && cycles < 6000);
    START = 1'b0;
    check_eq({tag, "_finished"}, int'(done | fail), 1);
  endtask

  task automatic scenario(input string tag, input int lo, input int hi, input int oor_at,
                          input int pulse_at, input int exp_done, input int exp_tc,
                          input int exp_inc, input int exp_dec, input int exp_cycles);
    int cyc;
    dirty_mask = mask_outside(lo, hi);
    oor_tap    = oor_at;
    run_training(tag, pulse_at, cyc);
    check_eq({tag, "_done"},    int'(done), exp_done);
    check_eq({tag, "_fail"},    int'(fail), 1 - exp_done);
    check_eq({tag, "_busy"},    int'(busy), 0);
    check_eq({tag, "_tc"},      int'(tap_center), exp_tc);
    check_eq({tag, "_inc"},     inc_cnt, exp_inc);
    check_eq({tag, "_dec"},     dec_cnt, exp_dec);
    check_eq({tag, "_loads"},   load_cnt, 1);
    check_eq({tag, "_overlap"}, overlap_cnt, 0);
    check_eq({tag, "_cycles"},  cyc, exp_cycles);
    check_eq({tag, "_tap"},     mon_tap, exp_inc - exp_dec);
    tick();
    check_eq({tag, "_sticky"},  int'(exp_done ? done : fail), 1);
  endtask

  initial begin
    int cyc;
    dirty_mask = '1;
    oor_tap    = 1000;
    mon_tap    = 0;
    load_cnt = 0; inc_cnt = 0; dec_cnt = 0; overlap_cnt = 0;

    // Reset held with START asserted: reset wins
    RESET_N = 1'b0;
    START   = 1'b1;
    tick();
    tick();
    check_idle_outputs("rst_with_start");
    START   = 1'b0;
    RESET_N = 1'b1;
    tick();
    check_idle_outputs("reset_state");

    // Window 10..39, stop at 40, centre 24; START re-pulsed while busy
    scenario("win10_39", 10, 39, 1000, 100, 1, 24, 40, 16, 1140);
`ifdef BCLK_TRAIN_WINDOW_OUT_EN
    check_eq("win_start_out", int'(win_start), 10);
    check_eq("win_end_out",   int'(win_end), 39);
`endif

    // Every tap dirty: full sweep, fail
    scenario("all_dirty", 1, 0, 1000, 0, 0, 0, 127, 0, 3457);

    // Clean only 10..12, too narrow
    scenario("narrow", 10, 12, 1000, 0, 0, 0, 13, 0, 379);

    // Clean from 30, delay line out of range at 50
    scenario("oor50", 30, 127, 50, 0, 1, 39, 50, 11, 1400);

    // Reset pulse during SAMPLE at tap 5, then a fresh full run
    dirty_mask = mask_outside(10, 39);
    oor_tap    = 1000;
    load_cnt = 0; inc_cnt = 0; dec_cnt = 0; overlap_cnt = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    cyc = 0;
    while (inc_cnt < 5 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check_eq("abort_reached_tap5", mon_tap, 5);
    repeat (12) tick();
    check_eq("abort_busy_before", int'(busy), 1);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    check_idle_outputs("abort");
    repeat (3) tick();
    check_eq("abort_no_pulses", inc_cnt, 5);
    scenario("after_abort", 10, 39, 1000, 0, 1, 24, 40, 16, 1140);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr3_bclk_training_ctrl.md
# ddr3_bclk_training_ctrl

Sequencer for the DDR3 BCLK training IOD lane. It drives the lane's dynamic delay line (load/move/direction) and eye-monitor flag clear, and sweeps the RX delay from tap 0 upward. At each tap it samples the EARLY/LATE eye-monitor flags to find the widest clean window, then steps the delay line back to the window centre. It sits in the fabric clock domain between the DDR PHY training logic (START/DONE/FAIL) and the BCLK_TRAINING IOD ports.

## Interface
Parameters:
- TAP_MAX, 127: last delay tap swept; 8-bit tap range.
- SETTLE_CYCLES, 8: cycles waited after each load/move before sampling; ≥1.
- SAMPLE_CYCLES, 16: cycles the eye-monitor flags are observed per tap; ≥1.
- MIN_WINDOW, 4: minimum clean-window width in taps for a pass.

Ports:
- FAB_CLK  in  1  sole clock; all logic is rising-edge.
- RESET_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request to run training; ignored while BUSY.
- EYE_MONITOR_EARLY  in  1  IOD early flag (sticky until cleared).
- EYE_MONITOR_LATE  in  1  IOD late flag (sticky until cleared).
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit indicator.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid whenever MOVE is high.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse clearing the IOD flags.
- BUSY  out  1  high from the cycle after accepted START until DONE or FAIL rises.
- DONE  out  1  sticky pass; cleared by the next accepted START.
- FAIL  out  1  sticky fail; cleared by the next accepted START.
- TAP_CENTER  out  8  final tap; valid when DONE is high, 0 on FAIL.

## Operation
- FSM states: IDLE → LOAD → CLEAR → SETTLE → SAMPLE → EVAL → (STEP → CLEAR | CENTER → FINISH | FAILED).
- IDLE: waits for START. On START: clear DONE/FAIL, tap=0, start_found=0. Go to LOAD.
- LOAD: DELAY_LINE_LOAD=1 for 1 cycle.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for 1 cycle; edge accumulator cleared.
- SETTLE: count SETTLE_CYCLES.
- SAMPLE: for SAMPLE_CYCLES, edge |= EARLY|LATE.
- EVAL (1 cycle), in priority order:
  - OUT_OF_RANGE=1: sweep ends and the current tap is excluded; win_end=tap−1.
  - edge=1 with start_found: win_end=tap−1; sweep ends.
  - edge=0 with no start_found: win_start=tap, start_found=1.
  - tap==TAP_MAX without an earlier end: if edge=0, win_end=tap; sweep ends.
  - Otherwise go to STEP.
- When the sweep ends:
  - No start_found, or (win_end−win_start+1) < MIN_WINDOW → FAILED.
  - Otherwise center=(win_start+win_end)>>1 (9-bit sum, truncate), then CENTER.
- STEP: MOVE=1, DIRECTION=1 for 1 cycle; tap+=1; go to CLEAR.
- CENTER: while tap>center, emit MOVE=1 with DIRECTION=0 on alternate cycles (1 high, 1 low) and decrement tap on each pulse. Then FINISH.
- FINISH: TAP_CENTER=tap, DONE=1, BUSY=0, go to IDLE.
- FAILED: FAIL=1, TAP_CENTER=0, BUSY=0, go to IDLE. The delay line is left where it stopped.
- The tap counter never wraps; TAP_MAX ends the sweep.

## Timing
- Reset values: every output is 0; FSM goes to IDLE; internal tap, window and accumulator registers are 0.
- RESET_N low mid-sweep aborts on the next edge with no further pulses. The IOD delay state is not restored; the next START reloads it.
- RESET_N low together with START: reset wins.
- START→LOAD pulse latency: 1 cycle. BUSY rises in the same cycle as LOAD.
- Per tap: CLEAR(1) + SETTLE_CYCLES + SAMPLE_CYCLES + EVAL(1) + STEP(1), which is 27 cycles at the defaults.
- Centering costs 2 cycles per back-step.
- DONE/FAIL rise 1 cycle after the last MOVE low cycle or after EVAL. START in that same cycle is accepted next cycle.
- MOVE, LOAD and CLEAR_FLAGS never assert in the same cycle.

## Configuration
- BCLK_TRAIN_WINDOW_OUT_EN:
  - Defined: adds outputs WIN_START[7:0] and WIN_END[7:0]. Both are registered, reset to 0, update at sweep end, and stay valid with DONE or FAIL.
  - Undefined: these ports do not exist and behaviour is otherwise identical.

## Test plan
- Defaults. Flags set at taps 0–9 and 40–127 → window 10–39, sweep stops at tap 40, 16 decrement MOVEs, DONE=1, TAP_CENTER=24.
- Flags set at every tap → 128 taps swept, 127 increment MOVEs, FAIL=1, TAP_CENTER=0, no decrement MOVEs.
- Clean only at taps 10–12 (width 3 < 4) → FAIL=1.
- Clean from tap 30, OUT_OF_RANGE asserted at tap 50 → window 30–49, 11 decrement MOVEs, DONE, TAP_CENTER=39.
- RESET_N low for 1 cycle during SAMPLE at tap 5 → all outputs 0 next cycle. A fresh START gives LOAD 1 cycle later and a full pass.
- START pulsed while BUSY → ignored; exactly one LOAD pulse per run. With the macro defined, WIN_START=10 and WIN_END=39 in the first scenario.
